// File: rtl/if_stage_if.sv
// Bundle of signals between the if_stage and its surroundings: instruction
// memory, hazard and branch controls, and the IF/ID register outputs.
// The master modport is the fetch stage. The slave modport is the
// memory, hazard unit and decode side.
// IF_STAGE_PERF_CNT_EN adds the fetch_count output.
interface if_stage_if #(
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               stall;
    logic               flush;
    logic               pcsrc;
    logic [63:0]        branch_target;
    logic [63:0]        pc_out;
    logic [31:0]        ifid_instr;
    logic [63:0]        ifid_pc;
    logic               ifid_valid;
    logic               misalign_err;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0]        fetch_count;
`endif

    modport master (
        input  imem_rdata, stall, flush, pcsrc, branch_target,
        output imem_addr, pc_out, ifid_instr, ifid_pc, ifid_valid, misalign_err
`ifdef IF_STAGE_PERF_CNT_EN
        , output fetch_count
`endif
    );

    modport slave (
        output imem_rdata, stall, flush, pcsrc, branch_target,
        input  imem_addr, pc_out, ifid_instr, ifid_pc, ifid_valid, misalign_err
`ifdef IF_STAGE_PERF_CNT_EN
        , input fetch_count
`endif
    );
endinterface

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage. It holds the PC, addresses the instruction
// memory, and registers the fetched word and its PC into IF/ID.
// A branch redirect (pcsrc) has priority over a stall. A flush or a redirect
// puts a bubble into IF/ID. misalign_err is sticky until reset.
// IF_STAGE_PERF_CNT_EN adds a saturating count of valid IF/ID loads.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 6
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [31:0] instr_q;
    logic [63:0] ipc_q;
    logic        valid_q;
    logic        mis_q;
    logic        load_normal;
    logic        bubble;

    assign bubble      = bus.flush | bus.pcsrc;
    assign load_normal = ~bubble & ~bus.stall;

    // Next-PC select: redirect, then hold on stall, then sequential (wraps at 2^64).
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (bus.pcsrc) begin
            pc_d = {bus.branch_target[63:2], 2'b00};
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID register: a bubble wins over a stall, and a stall wins over a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'h0;
            ipc_q   <= 64'h0;
            valid_q <= 1'b0;
        end else if (bubble) begin
            instr_q <= 32'h0;
            ipc_q   <= 64'h0;
            valid_q <= 1'b0;
        end else if (!bus.stall) begin
            instr_q <= bus.imem_rdata;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
        end
    end

    // Sticky flag for a redirect to a target that is not word-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (bus.pcsrc && (bus.branch_target[1:0] != 2'b00)) begin
            mis_q <= 1'b1;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Saturating count of valid instructions loaded on the normal path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 32'h0;
        end else if (load_normal && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.fetch_count = cnt_q;
`endif

    assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
    assign bus.pc_out       = pc_q;
    assign bus.ifid_instr   = instr_q;
    assign bus.ifid_pc      = ipc_q;
    assign bus.ifid_valid   = valid_q;
    assign bus.misalign_err = mis_q;
endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage. A table of input and expected-output records is
// driven one clock edge at a time. Each expected record is pushed to a
// queue when its stimulus is applied, then popped and compared after the
// edge. Hand-written sequences cover PC wrap, address aliasing, and an
// asynchronous reset in the middle of a run.
module tb_if_stage;
    logic clk;
    logic reset;

    if_stage_if #(.IMEM_AW(6)) bus ();

    if_stage #(.RESET_PC(64'h0), .IMEM_AW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [64];
    assign bus.imem_rdata = imem[bus.imem_addr];

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [63:0] target;
        logic [63:0] exp_pc;
        logic [63:0] exp_ipc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_mis;
        logic        load;
    } vec_t;

    vec_t vecs [12];
    vec_t sb_q [$];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                             input logic [31:0] instr, input logic valid, input logic mis);
        check({tag, " pc_out"},       bus.pc_out, pc);
        check({tag, " imem_addr"},    64'(bus.imem_addr), 64'(pc[7:2]));
        check({tag, " ifid_pc"},      bus.ifid_pc, ipc);
        check({tag, " ifid_instr"},   64'(bus.ifid_instr), 64'(instr));
        check({tag, " ifid_valid"},   64'(bus.ifid_valid), 64'(valid));
        check({tag, " misalign_err"}, 64'(bus.misalign_err), 64'(mis));
    endtask

    initial begin
        vec_t e;
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | 32'(i);
        imem[0] = 32'hF840_0020;
        imem[1] = 32'h8B02_0023;
        imem[2] = 32'hB400_00A4;
        imem[3] = 32'hF800_0025;

        //           stall flush pcsrc target    exp_pc     exp_ipc  exp_instr    v  mis load
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  64'h0,  32'hF840_0020, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'h8B02_0023, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'h8B02_0023, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'h8B02_0023, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,  64'hC,  64'h8,  32'hB400_00A4, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'h40, 64'h40, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,  64'h44, 64'h40, 32'hA000_0010, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 64'h22, 64'h20, 64'h0,  32'h0,         1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,  64'h24, 64'h20, 32'hA000_0008, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 64'h0,  64'h24, 64'h0,  32'h0,         1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h0,  64'h28, 64'h0,  32'h0,         1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h0,  64'h2C, 64'h28, 32'hA000_000A, 1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.pcsrc = 1'b0;
        bus.branch_target = 64'h0;
        #12;
        check_all("reset", 64'h0, 64'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.stall = vecs[i].stall;
            bus.flush = vecs[i].flush;
            bus.pcsrc = vecs[i].pcsrc;
            bus.branch_target = vecs[i].target;
            sb_q.push_back(vecs[i]);
            if (vecs[i].load) exp_cnt++;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check_all($sformatf("vec%0d", i), e.exp_pc, e.exp_ipc, e.exp_instr, e.exp_valid, e.exp_mis);
        end

        // Redirect to the top of the address space, then wrap PC to 0.
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.pcsrc = 1'b1;
        bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk);
        #1;
        check_all("redir_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0, 1'b0, 1'b1);
        bus.pcsrc = 1'b0;
        bus.branch_target = 64'h0;
        exp_cnt++;
        @(posedge clk);
        #1;
        check_all("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hA000_003F, 1'b1, 1'b1);

        // Aliasing: PC 0x104 reads word 1.
        bus.pcsrc = 1'b1;
        bus.branch_target = 64'h104;
        @(posedge clk);
        #1;
        check("alias imem_addr", 64'(bus.imem_addr), 64'h1);
        bus.pcsrc = 1'b0;
        exp_cnt++;
        @(posedge clk);
        #1;
        check("alias instr", 64'(bus.ifid_instr), 64'h8B02_0023);
        check("alias ifid_pc", bus.ifid_pc, 64'h104);
`ifdef IF_STAGE_PERF_CNT_EN
        check("fetch_count", 64'(bus.fetch_count), 64'(exp_cnt));
`endif

        // Asynchronous reset while a stall and a redirect are pending.
        bus.stall = 1'b1;
        bus.pcsrc = 1'b1;
        bus.branch_target = 64'h80;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 64'h0, 64'h0, 32'h0, 1'b0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("fetch_count reset", 64'(bus.fetch_count), 64'h0);
`endif
        @(posedge clk);
        #1;
        check_all("reset_held", 64'h0, 64'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.pcsrc = 1'b0;
        bus.branch_target = 64'h0;
        @(posedge clk);
        #1;
        check_all("post_reset", 64'h4, 64'h0, 32'hF840_0020, 1'b1, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("fetch_count post", 64'(bus.fetch_count), 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
